shift_reg_bidir: RTL

Parametrised bidirectional multi-lane shift register, the successor to the single-bit serial-in/serial-out shift register. It holds DEPTH stages of WIDTH bits each. It supports hold, shift-up, shift-down and parallel load, exposes both end stages and the full contents, and tracks fill level with a saturating shift counter. It sits between serial data sources and word-oriented logic as a SIPO/PISO/delay-line primitive.

---
 rtl/shift_reg_bidir_if.sv | 28 ++
 rtl/shift_reg_bidir.sv | 110 +++++++++++
 2 files changed

// File: rtl/shift_reg_bidir_if.sv
// Bus bundle for shift_reg_bidir: control, serial/parallel data in, register views out.
interface shift_reg_bidir_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                     i_en;
  logic [1:0]               i_mode;
  logic                     i_rot;
  logic [WIDTH-1:0]         i_din;
  logic [WIDTH*DEPTH-1:0]   i_load;
  logic [WIDTH*DEPTH-1:0]   o_q;
  logic [WIDTH-1:0]         o_dout_hi;
  logic [WIDTH-1:0]         o_dout_lo;
  logic [CW-1:0]            o_count;
  logic                     o_full;

  modport master (
    output i_en, i_mode, i_rot, i_din, i_load,
    input  o_q, o_dout_hi, o_dout_lo, o_count, o_full
  );

  modport slave (
    input  i_en, i_mode, i_rot, i_din, i_load,
    output o_q, o_dout_hi, o_dout_lo, o_count, o_full
  );
endinterface

// File: rtl/shift_reg_bidir.sv
// Bidirectional multi-lane shift register with parallel load and saturating
// fill counter. Optional rotate feature enabled by defining SHIFT_REG_ROTATE_EN.

// One storage stage: picks neighbour below (shift up), above (shift down) or load.
module shift_reg_bidir_stage #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] ld_in,
  output logic [WIDTH-1:0] q
);
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DN   = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Stage register: reset beats enable beats mode; HOLD keeps q.
  always_ff @(posedge i_clk) begin
    if (i_rst) q <= '0;
    else if (i_en) begin
      case (i_mode)
        MODE_UP:   q <= lo_in;
        MODE_DN:   q <= hi_in;
        MODE_LOAD: q <= ld_in;
        default:   q <= q;
      endcase
    end
  end
endmodule

module shift_reg_bidir #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  shift_reg_bidir_if.slave  bus
);
  localparam int         CW        = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DN   = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [DEPTH-1:0][WIDTH-1:0] stage;
  logic [DEPTH-1:0][WIDTH-1:0] ld;
  logic [WIDTH-1:0]            up_src, dn_src;
  logic [CW-1:0]               cnt;
  logic                        rot_act;

`ifdef SHIFT_REG_ROTATE_EN
  assign rot_act = bus.i_rot;
`else
  // Rotate input exists on the bus but has no effect in this build.
  logic unused_rot;
  assign unused_rot = bus.i_rot;
  assign rot_act    = 1'b0;
`endif

  assign ld     = bus.i_load;
  // End-stage feed: serial input, or the opposite end when rotating.
  assign up_src = rot_act ? stage[DEPTH-1] : bus.i_din;
  assign dn_src = rot_act ? stage[0]       : bus.i_din;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] lo_n, hi_n;
    if (k == 0) begin : g_lo_end
      assign lo_n = up_src;
    end else begin : g_lo_mid
      assign lo_n = stage[k-1];
    end
    if (k == DEPTH-1) begin : g_hi_end
      assign hi_n = dn_src;
    end else begin : g_hi_mid
      assign hi_n = stage[k+1];
    end
    shift_reg_bidir_stage #(.WIDTH(WIDTH)) u_stage (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (bus.i_en),
      .i_mode (bus.i_mode),
      .lo_in  (lo_n),
      .hi_in  (hi_n),
      .ld_in  (ld[k]),
      .q      (stage[k])
    );
  end

  // Fill counter: load saturates immediately, serial shifts count up to DEPTH,
  // rotations move no new data in and leave it alone.
  always_ff @(posedge i_clk) begin
    if (i_rst) cnt <= '0;
    else if (bus.i_en) begin
      if (bus.i_mode == MODE_LOAD) cnt <= CNT_MAX;
      else if ((bus.i_mode == MODE_UP || bus.i_mode == MODE_DN) &&
               !rot_act && cnt != CNT_MAX)
        cnt <= cnt + CW'(1);
    end
  end

  assign bus.o_q       = stage;
  assign bus.o_dout_hi = stage[DEPTH-1];
  assign bus.o_dout_lo = stage[0];
  assign bus.o_count   = cnt;
  assign bus.o_full    = (cnt == CNT_MAX);
endmodule
